packet_admit_dispatch: RTL and testbench

PACKET_ADMIT_DISPATCH -- requirements
Module: packet_admit_dispatch

---
 rtl/packet_admit_dispatch_pkg.sv | 38 +++
 rtl/packet_admit_dispatch_if.sv | 11 +
 rtl/packet_admit_dispatch_occ.sv | 38 +++
 rtl/packet_admit_dispatch.sv | 129 ++++++++++++
 tb/tb_packet_admit_dispatch.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/packet_admit_dispatch_pkg.sv
// Shared packet type codes, traffic classes and dispatcher FSM encodings.
package pmd_pkg;

    localparam int DATA_W = 9;
    localparam int CTRL_W = 19;

    localparam logic [2:0] TYPE_TS_MAX = 3'd2;
    localparam logic [2:0] TYPE_RC_MIN = 3'd3;
    localparam logic [2:0] TYPE_RC_MAX = 3'd4;
    localparam logic [2:0] TYPE_BE     = 3'd5;
    localparam logic [2:0] TYPE_NMAC   = 3'd6;
    localparam logic [2:0] TYPE_RSV    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_NMAC = 2'd2,
        ST_DISC = 2'd3
    } pmd_state_e;

    typedef enum logic [2:0] {
        CLS_TS,
        CLS_RC,
        CLS_BE,
        CLS_NMAC,
        CLS_RSV
    } pkt_class_e;

    function automatic pkt_class_e decode_type(input logic [2:0] t);
        if (t == TYPE_RSV)                          return CLS_RSV;
        if (t <= TYPE_TS_MAX)                       return CLS_TS;
        if (t >= TYPE_RC_MIN && t <= TYPE_RC_MAX)   return CLS_RC;
        if (t == TYPE_BE)                           return CLS_BE;
        if (t == TYPE_NMAC)                         return CLS_NMAC;
        return CLS_RSV;
    endfunction

endpackage

// File: rtl/packet_admit_dispatch_if.sv
// Byte stream bundle: 9-bit data with delimiter, byte valid and packet control word.
interface pmd_stream_if;
    import pmd_pkg::*;

    logic [DATA_W-1:0] data;
    logic              wr;
    logic [CTRL_W-1:0] ctrl;

    modport master (output data, wr, ctrl);
    modport slave  (input  data, wr, ctrl);
endinterface

// File: rtl/packet_admit_dispatch_occ.sv
// Per-flow in-flight TS packet counters with combinational lookup of one flow.
module flow_occupancy_table #(
    parameter int FLOW_NUM = 32,
    parameter int FLOW_W   = 5,
    parameter int CNT_W    = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inc_wr,
    input  logic [FLOW_W-1:0] iv_inc_id,
    input  logic              i_rel_wr,
    input  logic [FLOW_W-1:0] iv_rel_id,
    input  logic [FLOW_W-1:0] iv_query_id,
    output logic [CNT_W-1:0]  ov_occ
);

    logic [CNT_W-1:0] r_occ [FLOW_NUM];

    assign ov_occ = r_occ[iv_query_id];

    // A release on an empty counter is dropped, so it cannot cancel a same-cycle increment.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < FLOW_NUM; i++) begin
            if (!i_rst_n) begin
                r_occ[i] <= '0;
            end else begin
                if ((i_inc_wr && iv_inc_id == FLOW_W'(i)) &&
                    !(i_rel_wr && iv_rel_id == FLOW_W'(i) && r_occ[i] != '0)) begin
                    r_occ[i] <= r_occ[i] + 1'b1;
                end else if (!(i_inc_wr && iv_inc_id == FLOW_W'(i)) &&
                             (i_rel_wr && iv_rel_id == FLOW_W'(i) && r_occ[i] != '0)) begin
                    r_occ[i] <= r_occ[i] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/packet_admit_dispatch.sv
// Admits TS/RC/BE packets to the forward stream, diverts NMAC packets and drops the rest.
module packet_admit_dispatch
    import pmd_pkg::*;
#(
    parameter int FLOW_NUM = 32,
    parameter int FLOW_W   = 5,
    parameter int TS_LIMIT = 4,
    parameter int CNT_W    = 4,
    parameter int BUFID_W  = 9
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    pmd_stream_if.slave         i_pkt,
    input  logic [FLOW_NUM-1:0] iv_ts_enable,
    input  logic [BUFID_W-1:0]  iv_free_bufid_cnt,
    input  logic [BUFID_W-1:0]  iv_rc_threshold,
    input  logic [BUFID_W-1:0]  iv_be_threshold,
    input  logic                i_release_wr,
    input  logic [FLOW_W-1:0]   iv_release_flowid,
    pmd_stream_if.master        o_pkt,
    output logic [DATA_W-1:0]   ov_nmac_data,
    output logic                o_nmac_data_wr,
    output logic                o_pkt_cnt_pulse,
    output logic                o_pkt_discard_pulse,
    output logic                o_ts_overflow_error_pulse,
    output logic [FLOW_W-1:0]   ov_overflow_flowid,
    output logic [1:0]          ov_state
);

    pmd_state_e        r_state;
    logic              r_abort;
    logic [DATA_W-1:0] r_fwd_data_p1, r_nmac_data_p1;
    logic              r_fwd_wr_p1, r_nmac_wr_p1;
    logic [CTRL_W-1:0] r_ctrl_p1;
    logic              r_cnt_pulse, r_disc_pulse, r_ovf_pulse;
    logic [FLOW_W-1:0] r_ovf_id;

    logic              w_delim, w_head, w_tail, w_in_pkt;
    pkt_class_e        w_cls;
    logic [FLOW_W-1:0] w_flow;
    logic [CNT_W-1:0]  w_occ;
    logic              w_ts_en, w_ts_room, w_admit, w_ovf;
    logic              w_fwd_byte, w_nmac_byte;
    pmd_state_e        w_enter;

    assign w_delim  = i_pkt.wr && i_pkt.data[8];
    assign w_head   = (r_state == ST_IDLE) && !r_abort && w_delim;
    assign w_tail   = (r_state != ST_IDLE) && w_delim;
    assign w_in_pkt = (r_state != ST_IDLE) || r_abort;
    assign w_cls    = decode_type(i_pkt.ctrl[18:16]);
    assign w_flow   = i_pkt.ctrl[FLOW_W-1:0];
    assign w_ts_en  = iv_ts_enable[w_flow];
    assign w_ts_room = w_occ < CNT_W'(TS_LIMIT);

    always_comb begin
        w_admit = 1'b0;
        case (w_cls)
            CLS_TS:  w_admit = w_ts_en && w_ts_room;
            CLS_RC:  w_admit = iv_free_bufid_cnt > iv_rc_threshold;
            CLS_BE:  w_admit = iv_free_bufid_cnt > iv_be_threshold;
            default: w_admit = 1'b0;
        endcase
    end

    assign w_enter     = w_admit ? ST_FWD : ((w_cls == CLS_NMAC) ? ST_NMAC : ST_DISC);
    assign w_ovf       = w_head && (w_cls == CLS_TS) && w_ts_en && !w_ts_room;
    assign w_fwd_byte  = i_pkt.wr && ((w_head && w_enter == ST_FWD) || r_state == ST_FWD);
    assign w_nmac_byte = i_pkt.wr && ((w_head && w_enter == ST_NMAC) || r_state == ST_NMAC);

    flow_occupancy_table #(
        .FLOW_NUM (FLOW_NUM),
        .FLOW_W   (FLOW_W),
        .CNT_W    (CNT_W)
    ) u_occ (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_inc_wr    (w_head && (w_cls == CLS_TS) && w_admit),
        .iv_inc_id   (w_flow),
        .i_rel_wr    (i_release_wr),
        .iv_rel_id   (iv_release_flowid),
        .iv_query_id (w_flow),
        .ov_occ      (w_occ)
    );

    // Reset keeps tracking packet boundaries so the tail of an aborted packet is not taken as a head.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_abort        <= w_in_pkt ? !w_delim : w_delim;
            r_fwd_data_p1  <= '0;
            r_fwd_wr_p1    <= 1'b0;
            r_nmac_data_p1 <= '0;
            r_nmac_wr_p1   <= 1'b0;
            r_ctrl_p1      <= '0;
            r_cnt_pulse    <= 1'b0;
            r_disc_pulse   <= 1'b0;
            r_ovf_pulse    <= 1'b0;
            r_ovf_id       <= '0;
        end else begin
            r_fwd_wr_p1  <= w_fwd_byte;
            r_nmac_wr_p1 <= w_nmac_byte;
            if (w_fwd_byte)  r_fwd_data_p1  <= i_pkt.data;
            if (w_nmac_byte) r_nmac_data_p1 <= i_pkt.data;
            if (w_head) begin
                r_state <= w_enter;
                if (w_admit) r_ctrl_p1 <= i_pkt.ctrl;
            end else if (w_tail) begin
                r_state <= ST_IDLE;
            end
            if (r_abort && w_delim) r_abort <= 1'b0;
            r_cnt_pulse  <= w_head;
            r_disc_pulse <= w_head && (w_enter == ST_DISC);
            r_ovf_pulse  <= w_ovf;
            if (w_ovf) r_ovf_id <= w_flow;
        end
    end

    assign o_pkt.data                = r_fwd_data_p1;
    assign o_pkt.wr                  = r_fwd_wr_p1;
    assign o_pkt.ctrl                = r_ctrl_p1;
    assign ov_nmac_data              = r_nmac_data_p1;
    assign o_nmac_data_wr            = r_nmac_wr_p1;
    assign o_pkt_cnt_pulse           = r_cnt_pulse;
    assign o_pkt_discard_pulse       = r_disc_pulse;
    assign o_ts_overflow_error_pulse = r_ovf_pulse;
    assign ov_overflow_flowid        = r_ovf_id;
    assign ov_state                  = r_state;

endmodule

// File: tb/tb_packet_admit_dispatch.sv
// Randomized bench for packet_admit_dispatch with a packet-level reference model.
module tb_packet_admit_dispatch;

    localparam int TS_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ts_en = '0;
    logic [8:0]  free_cnt = '0, rc_thr = '0, be_thr = '0;
    logic        rel_wr = 1'b0;
    logic [4:0]  rel_id = '0;
    logic [8:0]  nmac_data;
    logic        nmac_wr, cnt_pulse, disc_pulse, ovf_pulse;
    logic [4:0]  ovf_id;
    logic [1:0]  state;

    pmd_stream_if in_if ();
    pmd_stream_if out_if ();

    packet_admit_dispatch dut (
        .i_clk                     (clk),
        .i_rst_n                   (rst_n),
        .i_pkt                     (in_if),
        .iv_ts_enable              (ts_en),
        .iv_free_bufid_cnt         (free_cnt),
        .iv_rc_threshold           (rc_thr),
        .iv_be_threshold           (be_thr),
        .i_release_wr              (rel_wr),
        .iv_release_flowid         (rel_id),
        .o_pkt                     (out_if),
        .ov_nmac_data              (nmac_data),
        .o_nmac_data_wr            (nmac_wr),
        .o_pkt_cnt_pulse           (cnt_pulse),
        .o_pkt_discard_pulse       (disc_pulse),
        .o_ts_overflow_error_pulse (ovf_pulse),
        .ov_overflow_flowid        (ovf_id),
        .ov_state                  (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;
    // Reference model: packet destination (0 none, 1 fwd, 2 nmac, 3 drop), occupancy per flow.
    int          m_dest = 0;
    bit          m_skip = 1'b0;
    int          m_occ [32];
    logic [18:0] m_ctrl = '0;
    logic [4:0]  m_ovf_id = '0;
    int obs_fwd, obs_nmac, obs_cnt, obs_disc, obs_ovf;
    bit rnd_rel = 1'b0, rnd_gap = 1'b0, chg_mid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_obs();
        obs_fwd = 0; obs_nmac = 0; obs_cnt = 0; obs_disc = 0; obs_ovf = 0;
    endtask

    task automatic step(input logic [8:0] d, input logic wr, input logic [18:0] c,
                        input logic rel, input logic [4:0] rid);
        bit head, e_cnt, e_disc, e_ovf, adm;
        int dest_b, fl, typ, pre [32];
        in_if.data = d; in_if.wr = wr; in_if.ctrl = c;
        rel_wr = rel; rel_id = rid;
        e_cnt = 0; e_disc = 0; e_ovf = 0;
        foreach (pre[k]) pre[k] = m_occ[k];
        head = !m_skip && m_dest == 0 && wr && d[8];
        if (m_skip && wr && d[8]) m_skip = 1'b0;
        dest_b = m_dest;
        if (head) begin
            typ = int'(c[18:16]); fl = int'(c[4:0]);
            adm = 0;
            if (typ <= 2) begin
                adm = ts_en[fl] && pre[fl] < TS_LIMIT;
                e_ovf = ts_en[fl] && pre[fl] >= TS_LIMIT;
                if (adm) m_occ[fl]++;
            end else if (typ <= 4) adm = free_cnt > rc_thr;
            else if (typ == 5) adm = free_cnt > be_thr;
            dest_b = adm ? 1 : (typ == 6 ? 2 : 3);
            m_dest = dest_b;
            e_cnt = 1; e_disc = (dest_b == 3);
            if (adm) m_ctrl = c;
            if (e_ovf) m_ovf_id = c[4:0];
        end else if (m_dest != 0 && wr && d[8]) begin
            m_dest = 0;
        end
        if (rel && pre[rid] > 0) m_occ[rid]--;
        @(posedge clk); #1;
        check_eq("fwd_wr", out_if.wr, wr && dest_b == 1);
        if (wr && dest_b == 1) begin
            check_eq("fwd_data", out_if.data, d);
            check_eq("fwd_ctrl", out_if.ctrl, m_ctrl);
        end
        check_eq("nmac_wr", nmac_wr, wr && dest_b == 2);
        if (wr && dest_b == 2) check_eq("nmac_data", nmac_data, d);
        check_eq("cnt_pulse", cnt_pulse, e_cnt);
        check_eq("disc_pulse", disc_pulse, e_disc);
        check_eq("ovf_pulse", ovf_pulse, e_ovf);
        check_eq("ovf_id", ovf_id, m_ovf_id);
        check_eq("state", state, m_dest);
        obs_fwd += int'(out_if.wr); obs_nmac += int'(nmac_wr); obs_cnt += int'(cnt_pulse);
        obs_disc += int'(disc_pulse); obs_ovf += int'(ovf_pulse);
    endtask

    task automatic rst_step(input logic [8:0] d, input logic wr);
        bit in_pkt, delim;
        rst_n = 1'b0;
        in_if.data = d; in_if.wr = wr; in_if.ctrl = 19'($urandom);
        rel_wr = 1'b0;
        in_pkt = (m_dest != 0) || m_skip;
        delim = wr && d[8];
        m_skip = in_pkt ? !delim : delim;
        m_dest = 0; m_ovf_id = '0; m_ctrl = '0;
        foreach (m_occ[k]) m_occ[k] = 0;
        @(posedge clk); #1;
        check_eq("rst_fwd_wr", out_if.wr, 0);
        check_eq("rst_fwd_data", out_if.data, 0);
        check_eq("rst_fwd_ctrl", out_if.ctrl, 0);
        check_eq("rst_nmac", {nmac_wr, nmac_data}, 0);
        check_eq("rst_pulses", {cnt_pulse, disc_pulse, ovf_pulse}, 0);
        check_eq("rst_ovf_id", ovf_id, 0);
        check_eq("rst_state", state, 0);
        rst_n = 1'b1;
    endtask

    task automatic send_pkt(input logic [2:0] typ, input logic [4:0] fl, input int len,
                            input int rst_at, input logic hrel, input logic [4:0] hrid);
        logic [18:0] c;
        c = {typ, 11'($urandom), fl};
        for (int i = 0; i < len; i++) begin
            logic [8:0] d;
            logic       rel;
            logic [4:0] rid;
            d = {(i == 0 || i == len - 1), 8'($urandom)};
            if (rnd_gap) while ($urandom_range(0, 3) == 0) step(9'($urandom), 1'b0, c, 1'b0, 5'd0);
            rel = 1'b0; rid = '0;
            if (i == 0 && hrel) begin
                rel = 1'b1; rid = hrid;
            end else if (rnd_rel && $urandom_range(0, 3) == 0) begin
                rid = 5'($urandom_range(0, 7));
                rel = m_occ[rid] > 0;
            end
            if (chg_mid && i == 1) begin
                free_cnt = '0; rc_thr = '1; be_thr = '1;
            end
            if (i == rst_at) rst_step(d, 1'b1);
            else step(d, 1'b1, c, rel, rid);
        end
    endtask

    initial begin
        foreach (m_occ[k]) m_occ[k] = 0;
        in_if.data = '0; in_if.wr = 1'b0; in_if.ctrl = '0;
        repeat (3) rst_step(9'h0, 1'b0);
        step(9'h0, 1'b0, 19'h0, 1'b0, 5'd0);

        // TS flow 3 overflow after four in-flight packets
        ts_en = 32'h1 << 3;
        clr_obs();
        repeat (5) send_pkt(3'd0, 5'd3, 4, -1, 1'b0, 5'd0);
        check_eq("req043_fwd_bytes", obs_fwd, 16);
        check_eq("req043_disc", obs_disc, 1);
        check_eq("req043_ovf", obs_ovf, 1);
        check_eq("req043_ovf_id", ovf_id, 3);

        // Release on empty flow 0 must not wrap
        step(9'h0, 1'b0, 19'h0, 1'b1, 5'd0);
        ts_en = ts_en | 32'h1;
        clr_obs();
        repeat (5) send_pkt(3'd2, 5'd0, 3, -1, 1'b0, 5'd0);
        check_eq("req048_fwd_bytes", obs_fwd, 12);
        check_eq("req048_disc", obs_disc, 1);

        // Flow 7 full: same-cycle release and head is judged on the old count
        ts_en = ts_en | (32'h1 << 7);
        repeat (4) send_pkt(3'd1, 5'd7, 2, -1, 1'b0, 5'd0);
        clr_obs();
        send_pkt(3'd1, 5'd7, 4, -1, 1'b1, 5'd7);
        check_eq("req044_disc", obs_disc, 1);
        check_eq("req044_ovf_id", ovf_id, 7);
        clr_obs();
        send_pkt(3'd1, 5'd7, 4, -1, 1'b0, 5'd0);
        send_pkt(3'd1, 5'd7, 4, -1, 1'b0, 5'd0);
        check_eq("req044_after_fwd", obs_fwd, 4);
        check_eq("req044_after_disc", obs_disc, 1);

        // RC threshold is strict; decision frozen at the head
        free_cnt = 9'd100; rc_thr = 9'd100;
        clr_obs();
        send_pkt(3'd3, 5'd9, 64, -1, 1'b0, 5'd0);
        check_eq("req045_eq_fwd", obs_fwd, 0);
        check_eq("req045_eq_disc", obs_disc, 1);
        free_cnt = 9'd101; rc_thr = 9'd100; chg_mid = 1'b1;
        clr_obs();
        send_pkt(3'd4, 5'd9, 64, -1, 1'b0, 5'd0);
        chg_mid = 1'b0;
        check_eq("req045_gt_fwd", obs_fwd, 64);
        check_eq("req045_gt_disc", obs_disc, 0);

        // NMAC diversion
        clr_obs();
        send_pkt(3'd6, 5'd1, 60, -1, 1'b0, 5'd0);
        check_eq("req046_nmac", obs_nmac, 60);
        check_eq("req046_fwd", obs_fwd, 0);
        check_eq("req046_cnt", obs_cnt, 1);

        // Reset on byte 20 of a 64-byte TS packet; flow 3 was full before
        ts_en = '1;
        clr_obs();
        send_pkt(3'd0, 5'd5, 64, 19, 1'b0, 5'd0);
        check_eq("req047_fwd", obs_fwd, 19);
        check_eq("req047_cnt", obs_cnt, 1);
        clr_obs();
        send_pkt(3'd0, 5'd3, 4, -1, 1'b0, 5'd0);
        check_eq("req047_next_fwd", obs_fwd, 4);
        check_eq("req047_next_cnt", obs_cnt, 1);

        // Randomized traffic
        rnd_rel = 1'b1; rnd_gap = 1'b1;
        for (int p = 0; p < 300; p++) begin
            if (p % 25 == 0) ts_en = $urandom | $urandom;
            free_cnt = 9'($urandom);
            rc_thr = $urandom_range(0, 1) ? free_cnt : 9'($urandom);
            be_thr = $urandom_range(0, 1) ? free_cnt : 9'($urandom);
            if ($urandom_range(0, 5) == 0) step({1'b0, 8'($urandom)}, 1'b1, 19'($urandom), 1'b0, 5'd0);
            send_pkt(3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom_range(2, 12),
                     ($urandom_range(0, 29) == 0) ? 1 : -1, 1'b0, 5'd0);
        end
        repeat (2) step(9'h0, 1'b0, 19'h0, 1'b0, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
